// File: rtl/iob_cache_fe_arbiter.sv
// iob_cache_fe_arbiter: merges instruction (m0) and data (m1) IOb masters onto one
// cache port, one read in flight, response routed back to the issuing master.
// Ports: clk_i/cke_i/arst_n_i; m_* per-master lanes (master g at lane g); s_* cache port.
// Config: IOB_CACHE_ARB_FIXED_PRIO_EN selects fixed priority (m1 wins) instead of round-robin.
module iob_cache_fe_arbiter #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
) (
  input  logic                    clk_i,
  input  logic                    cke_i,
  input  logic                    arst_n_i,
  input  logic [1:0]              m_valid_i,
  input  logic [2*ADDR_W-1:0]     m_addr_i,
  input  logic [2*DATA_W-1:0]     m_wdata_i,
  input  logic [2*(DATA_W/8)-1:0] m_wstrb_i,
  output logic [1:0]              m_ready_o,
  output logic [1:0]              m_rvalid_o,
  output logic [2*DATA_W-1:0]     m_rdata_o,
  output logic                    s_valid_o,
  output logic [ADDR_W-1:0]       s_addr_o,
  output logic [DATA_W-1:0]       s_wdata_o,
  output logic [DATA_W/8-1:0]     s_wstrb_o,
  input  logic                    s_ready_i,
  input  logic                    s_rvalid_i,
  input  logic [DATA_W-1:0]       s_rdata_i
);

  localparam int STRB_W = DATA_W / 8;

  typedef enum logic {
    IDLE    = 1'b0,
    RD_WAIT = 1'b1
  } state_t;

  state_t state_q, state_d;
  logic   owner_q, owner_d;
  logic   lock_q, lock_d;
  logic   last_q, last_d;
`ifndef IOB_CACHE_ARB_FIXED_PRIO_EN
  logic   rr_q, rr_d;
`endif

  logic grant;
  logic idle;
  logic acc;
  logic rd;

  // A stalled request keeps its grant so s_* stays stable until accepted.
  always_comb begin
    grant = 1'b0;
    if (lock_q) begin
      grant = last_q;
    end else begin
      unique case (m_valid_i)
        2'b10:   grant = 1'b1;
`ifdef IOB_CACHE_ARB_FIXED_PRIO_EN
        2'b11:   grant = 1'b1;
`else
        2'b11:   grant = rr_q;
`endif
        default: grant = 1'b0;
      endcase
    end
  end

  always_comb begin
    idle      = (state_q == IDLE);
    s_valid_o = arst_n_i & idle & (|m_valid_i);
    s_addr_o  = grant ? m_addr_i[ADDR_W +: ADDR_W]
                      : m_addr_i[0 +: ADDR_W];
    s_wdata_o = grant ? m_wdata_i[DATA_W +: DATA_W]
                      : m_wdata_i[0 +: DATA_W];
    s_wstrb_o = grant ? m_wstrb_i[STRB_W +: STRB_W]
                      : m_wstrb_i[0 +: STRB_W];
    rd        = (s_wstrb_o == '0);
    acc       = s_valid_o & s_ready_i;
    m_ready_o = 2'b00;
    if (s_valid_o) m_ready_o[grant] = s_ready_i;
    m_rvalid_o = 2'b00;
    if (arst_n_i && !idle && s_rvalid_i) m_rvalid_o[owner_q] = 1'b1;
    m_rdata_o = {2{s_rdata_i}};
  end

  always_comb begin
    state_d = state_q;
    owner_d = owner_q;
    lock_d  = lock_q;
    last_d  = last_q;
`ifndef IOB_CACHE_ARB_FIXED_PRIO_EN
    rr_d    = rr_q;
`endif
    unique case (state_q)
      IDLE: begin
        if (acc) begin
          lock_d = 1'b0;
          last_d = grant;
`ifndef IOB_CACHE_ARB_FIXED_PRIO_EN
          rr_d   = ~grant;
`endif
          if (rd) begin
            owner_d = grant;
            state_d = RD_WAIT;
          end
        end else if (s_valid_o) begin
          lock_d = 1'b1;
          last_d = grant;
        end
      end
      RD_WAIT: begin
        if (s_rvalid_i) state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk_i or negedge arst_n_i) begin
    if (!arst_n_i) begin
      state_q <= IDLE;
      owner_q <= 1'b0;
      lock_q  <= 1'b0;
      last_q  <= 1'b0;
`ifndef IOB_CACHE_ARB_FIXED_PRIO_EN
      rr_q    <= 1'b0;
`endif
    end else if (cke_i) begin
      state_q <= state_d;
      owner_q <= owner_d;
      lock_q  <= lock_d;
      last_q  <= last_d;
`ifndef IOB_CACHE_ARB_FIXED_PRIO_EN
      rr_q    <= rr_d;
`endif
    end
  end

endmodule
